// File: rtl/uart_tx_channel_mux.sv
// Round-robin multiplexer of NUM_REQ byte streams onto one uart_tx byte stream.
// Each grant sends a header byte (HEADER_BASE + source) and then up to MAX_BURST payload bytes.
module uart_tx_channel_mux #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_BURST   = 16,
  parameter logic [7:0]  HEADER_BASE = 8'hF0,
  localparam int unsigned IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   s_tvalid,
  output logic [NUM_REQ-1:0]   s_tready,
  input  logic [8*NUM_REQ-1:0] s_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [7:0]           m_tdata,
  output logic [IW-1:0]        grant_idx,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   count_q, count_d;

  logic [7:0]      src_byte [NUM_REQ];
  logic            src_valid;
  logic [IW-1:0]   rr_pick;
  logic            rr_found;
  logic [IW-1:0]   grant_inc;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      src_byte[i] = s_tdata[8*i +: 8];
    end
  end

  assign src_valid = s_tvalid[grant_q];
  assign grant_inc = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);

  // First requester found scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    rr_pick  = rr_ptr_q;
    rr_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!rr_found && s_tvalid[IW'(idx)]) begin
        rr_found = 1'b1;
        rr_pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    count_d  = count_q;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    s_tready = '0;
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = StHeader;
        end
      end
      StHeader: begin
        m_tvalid = 1'b1;
        m_tdata  = HEADER_BASE + 8'(grant_q);
        if (m_tready) begin
          state_d = StPayload;
          count_d = '0;
        end
      end
      StPayload: begin
        m_tvalid          = src_valid;
        m_tdata           = src_byte[grant_q];
        s_tready[grant_q] = m_tready;
        if (src_valid && m_tready) begin
          count_d = count_q + 1'b1;
          if (count_q == CW'(MAX_BURST - 1)) begin
            state_d  = StIdle;
            rr_ptr_d = grant_inc;
          end
        end else if (!src_valid && count_q != '0) begin
          // Source went idle after at least one payload byte: release the channel.
          state_d  = StIdle;
          rr_ptr_d = grant_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_channel_mux.sv
// Bench for uart_tx_channel_mux: default instance plus a MAX_BURST=1 / HEADER_BASE=FE instance.
// Per-source byte queues feed the DUTs; expected output bytes are queued and compared on arrival.
module tb_uart_tx_channel_mux;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m_tready = 1'b1;

  logic [N-1:0]   a_s_tvalid = '0, a_s_tready;
  logic [8*N-1:0] a_s_tdata = '0;
  logic           a_m_tvalid, a_busy;
  logic [7:0]     a_m_tdata;
  logic [1:0]     a_grant;

  logic [N-1:0]   b_s_tvalid = '0, b_s_tready;
  logic [8*N-1:0] b_s_tdata = '0;
  logic           b_m_tvalid, b_busy;
  logic [7:0]     b_m_tdata;
  logic [1:0]     b_grant;

  logic [7:0] srca_q [N][$];
  logic [7:0] srcb_q [N][$];
  logic [7:0] obsa_q [$], obsb_q [$], expa_q [$], expb_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int ready_pct = 100;
  logic [N-1:0] acc_a, acc_b;
  logic         samp_valid, samp_ready;
  logic [7:0]   samp_data;

  always #5 clk = ~clk;

  uart_tx_channel_mux u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (a_s_tvalid),
    .s_tready (a_s_tready),
    .s_tdata  (a_s_tdata),
    .m_tvalid (a_m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (a_m_tdata),
    .grant_idx(a_grant),
    .busy     (a_busy)
  );

  uart_tx_channel_mux #(
    .NUM_REQ    (4),
    .MAX_BURST  (1),
    .HEADER_BASE(8'hFE)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (b_s_tvalid),
    .s_tready (b_s_tready),
    .s_tdata  (b_s_tdata),
    .m_tvalid (b_m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (b_m_tdata),
    .grant_idx(b_grant),
    .busy     (b_busy)
  );

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      a_s_tvalid[i]       = (srca_q[i].size() != 0);
      a_s_tdata[8*i +: 8] = (srca_q[i].size() != 0) ? srca_q[i][0] : 8'h00;
      b_s_tvalid[i]       = (srcb_q[i].size() != 0);
      b_s_tdata[8*i +: 8] = (srcb_q[i].size() != 0) ? srcb_q[i][0] : 8'h00;
    end
  endtask

  // One clock: sample handshakes at negedge, update sources after the posedge.
  task automatic step();
    @(negedge clk);
    if (a_m_tvalid && m_tready) obsa_q.push_back(a_m_tdata);
    if (b_m_tvalid && m_tready) obsb_q.push_back(b_m_tdata);
    acc_a      = a_s_tvalid & a_s_tready;
    acc_b      = b_s_tvalid & b_s_tready;
    samp_valid = a_m_tvalid;
    samp_ready = m_tready;
    samp_data  = a_m_tdata;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_a[i] && srca_q[i].size() != 0) void'(srca_q[i].pop_front());
      if (acc_b[i] && srcb_q[i].size() != 0) void'(srcb_q[i].pop_front());
    end
    drive();
    m_tready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic run(input int limit);
    for (int c = 0; c < limit; c++) begin
      if (obsa_q.size() >= expa_q.size() && obsb_q.size() >= expb_q.size()) break;
      step();
    end
    repeat (6) step();
  endtask

  task automatic test_reset();
    #3;
    n_cmp += 4;
    if (a_m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_tvalid: got %b want 0", a_m_tvalid); end
    if (a_s_tready !== 4'h0) begin n_err++; $display("FAIL reset_s_tready: got %h want 0", a_s_tready); end
    if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    if (a_grant !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", a_grant); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    srca_q[2].push_back(8'h11); srca_q[2].push_back(8'h22); srca_q[2].push_back(8'h33);
    expa_q.push_back(8'hF2); expa_q.push_back(8'h11); expa_q.push_back(8'h22); expa_q.push_back(8'h33);
    run(200);
    n_cmp++;
    if (obsa_q.size() != expa_q.size()) begin
      n_err++; $display("FAIL single_count: got %0d want %0d", obsa_q.size(), expa_q.size());
    end
    while (obsa_q.size() != 0 && expa_q.size() != 0) begin
      logic [7:0] o, e;
      o = obsa_q.pop_front(); e = expa_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL single_byte: got %h want %h", o, e); end
    end
    obsa_q.delete(); expa_q.delete();
    n_cmp += 2;
    if (a_busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy=%b want 0", a_busy); end
    if (a_grant !== 2'd2) begin n_err++; $display("FAIL single_grant: got %0d want 2", a_grant); end
  endtask

  task automatic test_burst_limit();
    for (int i = 0; i < 40; i++) srca_q[0].push_back(8'(i));
    for (int i = 0; i < 3; i++) srca_q[1].push_back(8'(8'hA0 + i));
    expa_q.push_back(8'hF0);
    for (int i = 0; i < 16; i++) expa_q.push_back(8'(i));
    expa_q.push_back(8'hF1);
    for (int i = 0; i < 3; i++) expa_q.push_back(8'(8'hA0 + i));
    expa_q.push_back(8'hF0);
    for (int i = 16; i < 32; i++) expa_q.push_back(8'(i));
    expa_q.push_back(8'hF0);
    for (int i = 32; i < 40; i++) expa_q.push_back(8'(i));
    run(500);
    n_cmp++;
    if (obsa_q.size() != expa_q.size()) begin
      n_err++; $display("FAIL burst_count: got %0d want %0d", obsa_q.size(), expa_q.size());
    end
    for (int k = 0; obsa_q.size() != 0 && expa_q.size() != 0; k++) begin
      logic [7:0] o, e;
      o = obsa_q.pop_front(); e = expa_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL burst_byte[%0d]: got %h want %h", k, o, e); end
    end
    obsa_q.delete(); expa_q.delete();
  endtask

  task automatic test_backpressure();
    logic       pv, pr;
    logic [7:0] pd;
    int         stalls = 0;
    for (int i = 0; i < 6; i++) begin
      srca_q[1].push_back(8'(8'hC0 + i));
      srca_q[3].push_back(8'(8'hD0 + i));
    end
    expa_q.push_back(8'hF1);
    for (int i = 0; i < 6; i++) expa_q.push_back(8'(8'hC0 + i));
    expa_q.push_back(8'hF3);
    for (int i = 0; i < 6; i++) expa_q.push_back(8'(8'hD0 + i));
    ready_pct = 30;
    step();
    for (int c = 0; c < 1000 && obsa_q.size() < expa_q.size(); c++) begin
      pv = samp_valid; pr = samp_ready; pd = samp_data;
      step();
      if (pv && !pr) begin
        stalls++; n_cmp++;
        if (samp_valid !== 1'b1 || samp_data !== pd) begin
          n_err++;
          $display("FAIL bp_stable: got valid=%b data=%h want valid=1 data=%h", samp_valid,
                   samp_data, pd);
        end
      end
    end
    ready_pct = 100;
    repeat (6) step();
    n_cmp++;
    if (obsa_q.size() != expa_q.size()) begin
      n_err++; $display("FAIL bp_count: got %0d want %0d", obsa_q.size(), expa_q.size());
    end
    for (int k = 0; obsa_q.size() != 0 && expa_q.size() != 0; k++) begin
      logic [7:0] o, e;
      o = obsa_q.pop_front(); e = expa_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL bp_byte[%0d]: got %h want %h", k, o, e); end
    end
    obsa_q.delete(); expa_q.delete();
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 10; i++) srca_q[0].push_back(8'(8'h80 + i));
    repeat (5) step();
    n_cmp++;
    if (a_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", a_busy); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (a_m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_m_tvalid: got %b want 0", a_m_tvalid); end
    if (a_s_tready !== 4'h0) begin n_err++; $display("FAIL mid_s_tready: got %h want 0", a_s_tready); end
    if (a_busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", a_busy); end
    for (int i = 0; i < N; i++) srca_q[i].delete();
    drive();
    obsa_q.delete(); expa_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    srca_q[1].push_back(8'h5A); srca_q[1].push_back(8'h5B);
    expa_q.push_back(8'hF1); expa_q.push_back(8'h5A); expa_q.push_back(8'h5B);
    run(200);
    n_cmp++;
    if (obsa_q.size() != expa_q.size()) begin
      n_err++; $display("FAIL mid_count: got %0d want %0d", obsa_q.size(), expa_q.size());
    end
    for (int k = 0; obsa_q.size() != 0 && expa_q.size() != 0; k++) begin
      logic [7:0] o, e;
      o = obsa_q.pop_front(); e = expa_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL mid_byte[%0d]: got %h want %h", k, o, e); end
    end
    obsa_q.delete(); expa_q.delete();
  endtask

  // MAX_BURST=1 with HEADER_BASE=FE: strict rotation and a header that wraps past FF.
  task automatic test_round_robin_wrap();
    logic [7:0] hdr [N];
    hdr[0] = 8'hFE; hdr[1] = 8'hFF; hdr[2] = 8'h00; hdr[3] = 8'h01;
    for (int i = 0; i < N; i++) begin
      srcb_q[i].push_back(8'(16 * i));
      srcb_q[i].push_back(8'(16 * i + 1));
    end
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < N; i++) begin
        expb_q.push_back(hdr[i]);
        expb_q.push_back(8'(16 * i + j));
      end
    end
    run(300);
    n_cmp++;
    if (obsb_q.size() != expb_q.size()) begin
      n_err++; $display("FAIL rr_count: got %0d want %0d", obsb_q.size(), expb_q.size());
    end
    for (int k = 0; obsb_q.size() != 0 && expb_q.size() != 0; k++) begin
      logic [7:0] o, e;
      o = obsb_q.pop_front(); e = expb_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL rr_byte[%0d]: got %h want %h", k, o, e); end
    end
    obsb_q.delete(); expb_q.delete();
    n_cmp += 2;
    if (b_busy !== 1'b0) begin n_err++; $display("FAIL rr_idle: got busy=%b want 0", b_busy); end
    if (b_grant !== 2'd3) begin n_err++; $display("FAIL rr_grant: got %0d want 3", b_grant); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_limit();
    test_backpressure();
    test_reset_midframe();
    test_round_robin_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
